mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: DATA_W, default 32, operand and result width; the iteration counter width SHALL be derived as clog2(DATA_W)+1.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-low; reset==0 SHALL force reset state immediately, independent of clk.
REQ-004 mult_start  input  1  pulse from control unit requesting a signed multiply of a by b.
REQ-005 div_start  input  1  pulse from control unit requesting a signed divide of a by b.
REQ-006 a  input  DATA_W  operand A (regA output); dividend or multiplicand.
REQ-007 b  input  DATA_W  operand B (regB output); divisor or multiplier.
REQ-008 hi_out  output  DATA_W  HI register: product upper half, or remainder.
REQ-009 lo_out  output  DATA_W  LO register: product lower half, or quotient.
REQ-010 busy  output  1  high while an operation is in progress or completing.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 div_zero  output  1  high together with done when the completed divide had b==0.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FIN; busy SHALL equal (state!=IDLE).
REQ-014 In IDLE, a and b SHALL be sampled on the edge where mult_start or div_start is 1, and the FSM SHALL move to RUN with counter=0.
REQ-015 If mult_start and div_start are both 1, multiply SHALL win and div_start SHALL be ignored.
REQ-016 A start of either kind arriving in RUN or FIN SHALL be ignored without affecting the operation in progress.
REQ-017 Multiply SHALL use radix-2 Booth, one step per cycle, for DATA_W cycles; the result SHALL be the full signed 2*DATA_W product with hi=upper and lo=lower.
REQ-018 Divide SHALL use a restoring algorithm on magnitudes, one quotient bit per cycle, for DATA_W cycles.
REQ-019 The divide signs SHALL be fixed as: quotient truncated toward zero; remainder takes the sign of the dividend.
REQ-020 A divide of -2^(DATA_W-1) by -1 SHALL give lo=0x80000000 and hi=0, with no flag.
REQ-021 Timing: with the start sampled at edge E0, iterations SHALL occur at edges E1..E32.
REQ-022 At E32, hi_out and lo_out SHALL load together and the FSM SHALL enter FIN; done SHALL be 1 for exactly the cycle E32..E33; E33 SHALL return to IDLE.
REQ-023 A divide with b==0 at E0 SHALL go directly to FIN: done and div_zero SHALL be high during cycle E0..E1, and hi/lo SHALL be unchanged.
REQ-024 div_zero SHALL be 0 whenever done is 0.
REQ-025 hi_out and lo_out SHALL hold their last value until the next completion and SHALL never show partial results.
REQ-026 Operand changes on a and b after E0 SHALL NOT affect the result.

Reset
REQ-027 While reset==0: state=IDLE, counter=0, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, and internal working registers=0.
REQ-028 A reset asserted during RUN or FIN SHALL abort the operation with no done pulse; the first start after release SHALL behave as in REQ-014.

Structure
REQ-029 The FSM state encodings, DATA_W, and the MULT (funct 6'h18) and DIV (funct 6'h1a) codes SHALL reside in the shared MIPS definitions package used by control_unit.
REQ-030 The block SHALL be a single module with no sub-module; the Booth step and the restoring step SHALL share one DATA_W+1-bit adder/subtractor.

Verification
REQ-031 mult_start, a=7, b=0xFFFFFFFD -> done at E32..E33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high E0..E33.
REQ-032 mult_start, a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
REQ-033 div_start, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0; then a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 div_start, a=5, b=0 with hi/lo holding previous values -> done and div_zero high in cycle E0..E1, hi/lo unchanged, busy low after E1.
REQ-035 mult_start and div_start together with a=3, b=4 -> lo=12, hi=0; div_start at E10 with a=b=1 -> ignored, result unchanged, single done pulse.
REQ-036 reset driven low asynchronously mid-cycle at iteration 10 -> all outputs 0 immediately, no done; after release, mult 2x3 -> lo=6 at E32.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared MIPS definitions: datapath width, HI/LO funct codes and the
// multiply/divide unit state encoding.
package mult_div_unit_pkg;

  localparam int DATA_W = 32;

  // R-type funct codes that steer the control unit into this block
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1a;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on
// magnitudes). One step per cycle, DATA_W steps, results land in HI/LO.
// Handshake: a start pulse is accepted only while busy is low; done is a
// one-cycle pulse, and hi_out/lo_out are valid from that cycle until the
// next completion. div_zero qualifies done only.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_W = mult_div_unit_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_start,
  input  logic              div_start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output md_state_t         dbg_state
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  md_state_t          state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic [DATA_W:0]    acc;      // Booth accumulator / partial remainder
  logic [DATA_W-1:0]  qr;       // multiplier / dividend-then-quotient
  logic               q_m1;     // Booth look-behind bit
  logic [DATA_W-1:0]  m_reg;    // multiplicand / divisor magnitude
  logic               neg_q, neg_r, dz;
  logic [DATA_W-1:0]  hi_q, lo_q;

  logic [DATA_W:0]    op_x, op_y, r_shift, a_tmp, acc_nx;
  logic [DATA_W+1:0]  add_res;
  logic               sub;
  logic [DATA_W-1:0]  qr_nx, hi_fin, lo_fin, a_mag, b_mag;
  logic               q_m1_nx, last_iter;

  assign last_iter = (cnt == CNT_W'(DATA_W - 1));
  assign a_mag     = a[DATA_W-1] ? -a : a;
  assign b_mag     = b[DATA_W-1] ? -b : b;

  // One shared adder/subtractor plus the per-step Booth or restoring update
  always_comb begin
    sub     = 1'b0;
    r_shift = {acc[DATA_W-1:0], qr[DATA_W-1]};
    op_x    = acc;
    op_y    = {m_reg[DATA_W-1], m_reg};
    a_tmp   = acc;
    acc_nx  = acc;
    qr_nx   = qr;
    q_m1_nx = q_m1;
    if (is_div) begin
      op_x = r_shift;
      op_y = {1'b0, m_reg};
      sub  = 1'b1;
    end else begin
      sub  = qr[0] & ~q_m1;
    end
    add_res = {1'b0, op_x} + {1'b0, op_y ^ {(DATA_W+1){sub}}}
            + {{(DATA_W+1){1'b0}}, sub};
    if (is_div) begin
      // Carry out of the subtract means no borrow: keep the difference
      if (add_res[DATA_W+1]) begin
        acc_nx = add_res[DATA_W:0];
        qr_nx  = {qr[DATA_W-2:0], 1'b1};
      end else begin
        acc_nx = r_shift;
        qr_nx  = {qr[DATA_W-2:0], 1'b0};
      end
      q_m1_nx = 1'b0;
    end else begin
      if (qr[0] ^ q_m1) a_tmp = add_res[DATA_W:0];
      acc_nx  = {a_tmp[DATA_W], a_tmp[DATA_W:1]};
      qr_nx   = {a_tmp[0], qr[DATA_W-1:1]};
      q_m1_nx = qr[0];
    end
  end

  // Final result formatting: Booth product as-is, divide gets its signs back
  always_comb begin
    if (is_div) begin
      lo_fin = neg_q ? -qr_nx : qr_nx;
      hi_fin = neg_r ? -acc_nx[DATA_W-1:0] : acc_nx[DATA_W-1:0];
    end else begin
      lo_fin = qr_nx;
      hi_fin = acc_nx[DATA_W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; multiply wins over divide, zero divisor skips RUN
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (mult_start)                state_nx = ST_RUN;
        else if (div_start && b == '0) state_nx = ST_FIN;
        else if (div_start)            state_nx = ST_RUN;
      end
      ST_RUN:  if (last_iter) state_nx = ST_FIN;
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath registers: operand capture, iteration, result load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      acc    <= '0;
      qr     <= '0;
      q_m1   <= 1'b0;
      m_reg  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mult_start) begin
            cnt    <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            qr     <= b;
            q_m1   <= 1'b0;
            m_reg  <= a;
            dz     <= 1'b0;
          end else if (div_start) begin
            cnt    <= '0;
            is_div <= 1'b1;
            acc    <= '0;
            qr     <= a_mag;
            q_m1   <= 1'b0;
            m_reg  <= b_mag;
            neg_q  <= a[DATA_W-1] ^ b[DATA_W-1];
            neg_r  <= a[DATA_W-1];
            dz     <= (b == '0);
          end
        end
        ST_RUN: begin
          acc  <= acc_nx;
          qr   <= qr_nx;
          q_m1 <= q_m1_nx;
          cnt  <= cnt + CNT_W'(1);
          if (last_iter) begin
            hi_q <= hi_fin;
            lo_q <= lo_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign div_zero  = (state == ST_FIN) & dz;
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized + directed bench for mult_div_unit with a queue-based scoreboard.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mult_start = 1'b0;
  logic          div_start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  hi_out, lo_out;
  logic          busy, done, div_zero;
  md_state_t     dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [2*W:0]  exp_q[$];     // {div_zero, hi, lo}
  int            exp_cyc_q[$]; // cycle count at which done is due
  logic [W-1:0]  last_hi = '0, last_lo = '0;

  mult_div_unit #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a(a), .b(b), .hi_out(hi_out), .lo_out(lo_out), .busy(busy),
    .done(done), .div_zero(div_zero), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] model(input bit is_mul, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] pv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (is_mul) begin
      p  = sx * sy;
      pv = p;
      return {1'b0, pv[63:32], pv[31:0]};
    end
    if (y == '0) return {1'b1, last_hi, last_lo};
    q = sx / sy;   // truncates toward zero
    r = sx % sy;   // sign follows dividend
    return {1'b0, W'(r), W'(q)};
  endfunction

  // ---------------- driver ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input bit m, input bit d, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W:0] e;
    bit is_mul;
    wait_idle();
    mult_start = m;
    div_start  = d;
    a = x;
    b = y;
    is_mul = m;
    e = model(is_mul, x, y);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    exp_cyc_q.push_back((!is_mul && y == '0) ? cyc : cyc + W);
    last_hi = e[2*W-1:W];
    last_lo = e[W-1:0];
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    chk("busy_after_e0", 64'(busy), 64'd1);
    a = $urandom;   // operands must be irrelevant after capture
    b = $urandom;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [2*W:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(ec));
          chk("hi", 64'(hi_out), 64'(e[2*W-1:W]));
          chk("lo", 64'(lo_out), 64'(e[W-1:0]));
          chk("div_zero", 64'(div_zero), 64'(e[2*W]));
          chk("busy_at_done", 64'(busy), 64'd1);
        end
      end else if (div_zero) begin
        chk("div_zero_without_done", 64'(div_zero), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] x, y;
    int n;

    // reset state
    #12;
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;

    // directed cases
    issue(1, 0, 32'd7, 32'hFFFF_FFFD);
    issue(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    issue(0, 1, 32'hFFFF_FFF9, 32'd2);
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(0, 1, 32'd5, 32'd0);
    @(negedge clk);
    chk("dz_busy_after_e1", 64'(busy), 64'd0);
    chk("dz_hi_kept", 64'(hi_out), 64'd0);
    chk("dz_lo_kept", 64'(lo_out), 64'h8000_0000);

    // simultaneous starts, then a start while running that must be ignored
    issue(1, 1, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    div_start = 1'b1;
    a = 32'd1;
    b = 32'd1;
    @(negedge clk);
    div_start = 1'b0;

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: x = 32'h8000_0000;
        1: x = 32'(int'($urandom_range(0, 20)) - 10);
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'h8000_0000;
        3: y = 32'(int'($urandom_range(0, 20)) - 10);
        default: y = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0: issue(1, 0, x, y);
        1: issue(0, 1, x, y);
        default: issue(1, 1, x, y);
      endcase
    end

    // asynchronous reset mid-operation
    issue(1, 0, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_hi", 64'(hi_out), 64'd0);
    chk("mid_rst_lo", 64'(lo_out), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_dz", 64'(div_zero), 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    last_hi = '0;
    last_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    issue(1, 0, 32'd2, 32'd3);

    // drain outstanding expectations
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
